// File: rtl/prog_mem_fifo_pkg.sv
// Purpose: shared constants and types for the sequencer program memory.
// Latency: n/a (package only).
// Backpressure: n/a.
//
// Contents: instruction field positions, device indices, default sizing,
// and the read-side FSM state encoding.
package prog_mem_fifo_pkg;

    // Default sizing: 1024 instruction words of 2 x 16-bit host half-words.
    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;
    localparam int HALF_W     = 16;

    // Instruction word fields decoded by the sequencer.
    localparam int DEV_NO_LSB  = 0;
    localparam int DEV_NO_MSB  = 3;
    localparam int DEV_RST_BIT = 4;

    // Device indices carried in DEV_NO.
    localparam logic [3:0] DEV_ADC   = 4'd1;
    localparam logic [3:0] DEV_TIMER = 4'd7;

    // Read-side states: idle/waiting, RAM read in flight, head word presented.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FETCH = 2'd1,
        S_VALID = 2'd2
    } state_t;

endpackage

// File: rtl/prog_mem_fifo_ram.sv
// Purpose: simple dual-port RAM, one write port and one registered read port.
// Latency: read data appears 1 cycle after re/raddr are presented.
// Backpressure: none; every write and read is accepted.
//
// Ports: clk; we/waddr/wdata write port; re/raddr read request; rdata read data.
// No reset on the array or read register so it maps onto block RAM.
module prog_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/prog_mem_fifo.sv
// Purpose: sequencer program memory; packs host half-words into 32-bit words, replays on rewind.
// Latency: a committed word reaches mem_valid 2 cycles after it becomes fetchable; pop-to-next-valid >= 2 cycles.
// Backpressure: none to host (writes while full are dropped, overflow sticky); sequencer pops on mem_read rising edge.
//
// Ports: clk, rst_n (async active-low); host_we/host_data/host_clr from the pipe-in
// endpoint; mem_read/mem_zero from the sequencer; mem_in/mem_valid head word;
// prog_len/full/overflow status; prog_sum download checksum.
// Optional feature: define PROG_CHECKSUM_EN to build the prog_sum adder; otherwise prog_sum is 0.
module prog_mem_fifo
    import prog_mem_fifo_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              host_we,
    input  logic [15:0]       host_data,
    input  logic              host_clr,
    input  logic              mem_read,
    input  logic              mem_zero,
    output logic [DATA_W-1:0] mem_in,
    output logic              mem_valid,
    output logic [ADDR_W:0]   prog_len,
    output logic              full,
    output logic              overflow,
    output logic [15:0]       prog_sum
);

    localparam logic [ADDR_W:0] DEPTH_V = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic              phase_q, phase_d;
    logic [15:0]       hi_q, hi_d;
    logic [DATA_W-1:0] mem_in_q, mem_in_d;
    logic              mem_valid_q, mem_valid_d;
    logic              overflow_q, overflow_d;
    logic              mem_read_q, mem_read_d;
    state_t            state_q, state_d;

    logic              ram_we;
    logic              ram_re;
    logic [DATA_W-1:0] ram_rdata;
    logic              pop;

    assign full = (wr_ptr_q == DEPTH_V);
    assign pop  = mem_read & ~mem_read_q;

    prog_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr_q[ADDR_W-1:0]),
        .wdata ({hi_q, host_data}),
        .re    (ram_re),
        .raddr (rd_ptr_q[ADDR_W-1:0]),
        .rdata (ram_rdata)
    );

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        phase_d     = phase_q;
        hi_d        = hi_q;
        mem_in_d    = mem_in_q;
        mem_valid_d = mem_valid_q;
        overflow_d  = overflow_q;
        state_d     = state_q;
        mem_read_d  = mem_read;
        ram_we      = 1'b0;
        ram_re      = 1'b0;

        if (host_clr) begin
            // Erase overrides everything else this cycle; RAM contents are left
            // in place but become unreachable because wr_ptr returns to 0.
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            phase_d     = 1'b0;
            mem_valid_d = 1'b0;
            overflow_d  = 1'b0;
            state_d     = S_EMPTY;
        end else begin
            // Write side: the first half-word of a pair only lands in hi_q, so a
            // lone odd half-word never becomes visible to the sequencer.
            if (host_we) begin
                if (!phase_q) begin
                    hi_d    = host_data;
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (!full) begin
                        ram_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_ONE;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
            end

            // Read side: rewind wins over any fetch or pop in flight.
            if (mem_zero) begin
                rd_ptr_d    = '0;
                mem_valid_d = 1'b0;
                state_d     = S_EMPTY;
            end else begin
                case (state_q)
                    S_EMPTY: begin
                        // Compare against the registered wr_ptr: a word committed
                        // this cycle becomes fetchable next cycle.
                        if (rd_ptr_q < wr_ptr_q) begin
                            ram_re  = 1'b1;
                            state_d = S_FETCH;
                        end
                    end
                    S_FETCH: begin
                        mem_in_d    = ram_rdata;
                        mem_valid_d = 1'b1;
                        state_d     = S_VALID;
                    end
                    S_VALID: begin
                        if (pop) begin
                            mem_valid_d = 1'b0;
                            rd_ptr_d    = rd_ptr_q + PTR_ONE;
                            state_d     = S_EMPTY;
                        end
                    end
                    default: begin
                        state_d = S_EMPTY;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            phase_q     <= 1'b0;
            hi_q        <= '0;
            mem_in_q    <= '0;
            mem_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            mem_read_q  <= 1'b0;
            state_q     <= S_EMPTY;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            phase_q     <= phase_d;
            hi_q        <= hi_d;
            mem_in_q    <= mem_in_d;
            mem_valid_q <= mem_valid_d;
            overflow_q  <= overflow_d;
            mem_read_q  <= mem_read_d;
            state_q     <= state_d;
        end
    end

`ifdef PROG_CHECKSUM_EN
    logic [15:0] sum_q, sum_d;

    // Only half-words that can still be stored are summed; once full, both
    // halves of a pair are dropped, so neither contributes.
    always_comb begin
        sum_d = sum_q;
        if (host_clr) begin
            sum_d = '0;
        end else if (host_we && !full) begin
            sum_d = sum_q + host_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign prog_sum = sum_q;
`else
    assign prog_sum = 16'h0000;
`endif

    assign mem_in    = mem_in_q;
    assign mem_valid = mem_valid_q;
    assign prog_len  = wr_ptr_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_prog_mem_fifo.sv
// Testbench for prog_mem_fifo: directed program load/pop/rewind/full/clear
// scenarios with literal expectations, then randomized traffic compared every
// cycle against a behavioural model of the program memory.
module tb_prog_mem_fifo;

    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        host_we = 1'b0;
    logic [15:0] host_data = '0;
    logic        host_clr = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_zero = 1'b0;
    logic [31:0] mem_in;
    logic        mem_valid;
    logic [AW:0] prog_len;
    logic        full;
    logic        overflow;
    logic [15:0] prog_sum;

    int n_pass  = 0;
    int n_total = 0;
    bit cmp_en  = 1'b0;

    prog_mem_fifo #(.ADDR_W(AW), .DATA_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .host_we   (host_we),
        .host_data (host_data),
        .host_clr  (host_clr),
        .mem_read  (mem_read),
        .mem_zero  (mem_zero),
        .mem_in    (mem_in),
        .mem_valid (mem_valid),
        .prog_len  (prog_len),
        .full      (full),
        .overflow  (overflow),
        .prog_sum  (prog_sum)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [31:0] m_prog [DEPTH];
    int          m_wr = 0;       // committed words
    int          m_rd = 0;       // index of head word
    bit          m_half = 0;     // an odd half-word is pending
    logic [15:0] m_hi = '0;
    bit          m_valid = 0;
    logic [31:0] m_data = '0;
    bit          m_pend = 0;     // head word read issued, shows next cycle
    bit          m_ovf = 0;
    logic [15:0] m_sum = '0;
    bit          m_rdq = 0;

    always @(posedge clk) begin
        bit pop;
        int old_wr;
        pop   = mem_read && !m_rdq;
        m_rdq = mem_read;
        if (!rst_n) begin
            m_wr = 0; m_rd = 0; m_half = 0; m_valid = 0; m_pend = 0;
            m_ovf = 0; m_sum = '0; m_data = '0; m_rdq = 0;
        end else if (host_clr) begin
            m_wr = 0; m_rd = 0; m_half = 0; m_valid = 0; m_pend = 0;
            m_ovf = 0; m_sum = '0;
        end else begin
            old_wr = m_wr;
            if (host_we) begin
                if (m_wr < DEPTH) m_sum = m_sum + host_data;
                if (!m_half) begin
                    m_hi   = host_data;
                    m_half = 1;
                end else begin
                    m_half = 0;
                    if (m_wr < DEPTH) begin
                        m_prog[m_wr] = {m_hi, host_data};
                        m_wr = m_wr + 1;
                    end else begin
                        m_ovf = 1;
                    end
                end
            end
            if (mem_zero) begin
                m_rd = 0; m_valid = 0; m_pend = 0;
            end else if (m_pend) begin
                m_valid = 1; m_data = m_prog[m_rd]; m_pend = 0;
            end else if (m_valid) begin
                if (pop) begin
                    m_valid = 0; m_rd = m_rd + 1;
                end
            end else if (m_rd < old_wr) begin
                m_pend = 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en && rst_n) begin
            chk("mdl_valid", 32'(mem_valid), 32'(m_valid));
            if (m_valid) chk("mdl_mem_in", mem_in, m_data);
            chk("mdl_prog_len", 32'(prog_len), 32'(m_wr));
            chk("mdl_full", 32'(full), 32'(m_wr == DEPTH));
            chk("mdl_overflow", 32'(overflow), 32'(m_ovf));
`ifdef PROG_CHECKSUM_EN
            chk("mdl_prog_sum", 32'(prog_sum), 32'(m_sum));
`else
            chk("mdl_prog_sum", 32'(prog_sum), 32'h0);
`endif
        end
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic hw(input logic [15:0] d);
        host_we = 1'b1; host_data = d; tick(); host_we = 1'b0;
    endtask

    task automatic clr();
        host_clr = 1'b1; tick(); host_clr = 1'b0;
    endtask

    task automatic pop1();
        mem_read = 1'b1; tick(); mem_read = 1'b0; tick();
    endtask

    task automatic wait_valid(input string name, input int budget);
        int i;
        for (i = 0; i < budget && !mem_valid; i++) tick();
        if (!mem_valid) begin
            n_total++;
            $display("FAIL %s: mem_valid got 0 expected 1 within %0d cycles", name, budget);
        end
    endtask

    initial begin
        logic [15:0] a;
        logic [15:0] b;

        // Reset state
        repeat (3) tick();
        chk("rst_mem_valid", 32'(mem_valid), 32'h0);
        chk("rst_mem_in", mem_in, 32'h0);
        chk("rst_prog_len", 32'(prog_len), 32'h0);
        chk("rst_overflow", 32'(overflow), 32'h0);
        chk("rst_prog_sum", 32'(prog_sum), 32'h0);
        rst_n = 1'b1;
        tick();
        cmp_en = 1'b1;

        // Packing and pop order
        hw(16'h1234); hw(16'h5678); hw(16'hABCD); hw(16'h0011);
        chk("pack_prog_len", 32'(prog_len), 32'd2);
        wait_valid("pack_valid0", 2);
        chk("pack_word0", mem_in, 32'h12345678);
        pop1();
        wait_valid("pack_valid1", 3);
        chk("pack_word1", mem_in, 32'hABCD0011);
        pop1();
        repeat (3) tick();
        chk("pack_end_valid", 32'(mem_valid), 32'h0);

        // Held mem_read pops exactly once
        clr();
        hw(16'h1111); hw(16'h2222); hw(16'h3333); hw(16'h4444); hw(16'h5555); hw(16'h6666);
        wait_valid("hold_valid0", 3);
        chk("hold_word0", mem_in, 32'h11112222);
        mem_read = 1'b1; repeat (5) tick(); mem_read = 1'b0; tick();
        wait_valid("hold_valid1", 3);
        chk("hold_word1", mem_in, 32'h33334444);

        // Consume all, rewind with mem_zero
        pop1();
        wait_valid("rew_valid2", 3);
        chk("rew_word2", mem_in, 32'h55556666);
        pop1();
        repeat (3) tick();
        chk("rew_end_valid", 32'(mem_valid), 32'h0);
        mem_zero = 1'b1; tick(); mem_zero = 1'b0;
        chk("rew_zero_valid", 32'(mem_valid), 32'h0);
        wait_valid("rew_valid0", 3);
        chk("rew_word0", mem_in, 32'h11112222);
        chk("rew_prog_len", 32'(prog_len), 32'd3);

        // Full / overflow with depth 4
        clr();
        for (int k = 0; k < 5; k++) begin
            a = 16'hA000 + 16'(k);
            b = 16'hB000 + 16'(k);
            hw(a); hw(b);
            if (k == 3) begin
                chk("full_after4", 32'(full), 32'h1);
                chk("full_no_ovf", 32'(overflow), 32'h0);
            end
        end
        chk("full_overflow", 32'(overflow), 32'h1);
        chk("full_prog_len", 32'(prog_len), 32'd4);
        for (int k = 0; k < 4; k++) begin
            wait_valid("full_valid", 3);
            a = 16'hA000 + 16'(k);
            b = 16'hB000 + 16'(k);
            chk("full_word", mem_in, {a, b});
            pop1();
        end
        repeat (4) tick();
        chk("full_no_5th", 32'(mem_valid), 32'h0);

        // Odd half-word then erase
        clr();
        hw(16'hBEEF);
        repeat (4) tick();
        chk("odd_valid", 32'(mem_valid), 32'h0);
        chk("odd_prog_len", 32'(prog_len), 32'h0);
        clr();
        hw(16'h0001); hw(16'h0002);
        wait_valid("odd_valid_pair", 3);
        chk("odd_word", mem_in, 32'h00010002);

        // Checksum
        clr();
        hw(16'hFFFF); hw(16'h0002);
`ifdef PROG_CHECKSUM_EN
        chk("sum_wrap", 32'(prog_sum), 32'h0001);
`else
        chk("sum_off", 32'(prog_sum), 32'h0000);
`endif
        clr();
        chk("sum_clr", 32'(prog_sum), 32'h0000);

        // Randomized traffic with occasional erase, rewind and async reset
        for (int c = 0; c < 3000; c++) begin
            host_we   = ($urandom_range(0, 1) == 0);
            host_data = 16'($urandom);
            host_clr  = ($urandom_range(0, 79) == 0);
            mem_zero  = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 2) == 0) mem_read = ~mem_read;
            if (c == 1500) begin
                #2 rst_n = 1'b0;
                tick();
                #2 rst_n = 1'b1;
            end
            tick();
        end
        host_we = 1'b0; host_clr = 1'b0; mem_zero = 1'b0; mem_read = 1'b0;
        repeat (4) tick();

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/prog_mem_fifo.md
Name: prog_mem_fifo

Overview:
- Program memory directly upstream of the sequencer (logic_control).
- Host loads 16-bit half-words from the pipe-in endpoint. The block packs them into 32-bit instruction words and stores them in a dual-port RAM.
- The head word is presented to the sequencer as mem_in/mem_valid and popped on mem_read.
- mem_zero rewinds the read pointer without erasing the program, so auto-repeat mode can replay it.

Parameters:
- ADDR_W, 10, RAM address width; depth = 2**ADDR_W instruction words.
- DATA_W, 32, instruction word width; fixed at 2 x 16-bit host half-words.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- host_we  in  1  host half-word write strobe, one per cycle max
- host_data  in  16  host half-word
- host_clr  in  1  synchronous program erase
- mem_read  in  1  sequencer pop request; acts on rising edge only
- mem_zero  in  1  rewind/hold read pointer at 0 (level)
- mem_in  out  32  head instruction word
- mem_valid  out  1  mem_in holds an unconsumed word
- prog_len  out  ADDR_W+1  committed instruction count
- full  out  1  prog_len == 2**ADDR_W
- overflow  out  1  sticky: write attempted while full
- prog_sum  out  16  program checksum (see Optional Feature)

Behaviour:
- Reset values: wr_ptr=0, rd_ptr=0, half-word phase=0, mem_in=0, mem_valid=0, overflow=0, prog_len=0, prog_sum=0, state=S_EMPTY, mem_read edge register=0.
- Packing:
  - First host_we of a pair latches host_data into mem word bits [31:16].
  - Second host_we writes {latched, host_data} to RAM[wr_ptr]; wr_ptr increments; prog_len = wr_ptr.
  - A pending odd half-word is never visible to the sequencer.
- Full: when full, the second half-word write is dropped, overflow is set, and wr_ptr is unchanged.
- host_clr (sync):
  - Clears wr_ptr, rd_ptr, phase, mem_valid, overflow and prog_sum.
  - Overrides all other inputs in the same cycle.
- Pop:
  - pop = mem_read & ~mem_read_q.
  - A pop while mem_valid=0 is ignored.
  - A level held high pops once.
- RAM read port is registered, so read latency is 1 cycle.
- FSM:
  - S_EMPTY:
    - If rd_ptr < wr_ptr and mem_zero=0, issue read of RAM[rd_ptr] and go to S_FETCH.
    - Otherwise stay.
  - S_FETCH:
    - Capture RAM output into mem_in.
    - Set mem_valid=1.
    - Go to S_VALID.
  - S_VALID:
    - On pop: mem_valid=0, rd_ptr+1, go to S_EMPTY. The next word is therefore valid no sooner than 2 cycles after the pop.
- mem_zero=1, in any state:
  - rd_ptr<=0, mem_valid<=0, state<=S_EMPTY.
  - A pop in the same cycle is discarded.
  - Program contents, wr_ptr and prog_len are kept.
- Simultaneous host write and pop:
  - Both take effect.
  - A word committed in cycle N is eligible for fetch in N+1.
- End of program: rd_ptr == wr_ptr gives mem_valid=0 until host writes more or mem_zero rewinds.
- No pointer wrap:
  - rd_ptr never exceeds wr_ptr.
  - wr_ptr saturates at 2**ADDR_W.
- Reset mid-operation: async clear of all state. RAM contents are undefined and are not relied on because wr_ptr=0.

Optional Feature:
- Macro: PROG_CHECKSUM_EN.
- Defined:
  - prog_sum = 16-bit wrap-around sum of every accepted host half-word since the last reset or host_clr.
  - Dropped (overflow) half-words are excluded.
  - The host reads prog_sum back to verify the download.
- Undefined: prog_sum is tied to 16'h0000 and no adder is synthesised.

Decomposition:
- Shared package/header:
  - Instruction field constants: DEV_NO bits [3:0], DEV_RST bit 4.
  - Device index constants: ADC=1, TIMER=7.
  - Default ADDR_W.
  - FSM state encodings S_EMPTY/S_FETCH/S_VALID.
- Sub-module: prog_ram, a simple dual-port RAM (one write port, one registered read port, ADDR_W/DATA_W parameters), inferred as block RAM.

Test Plan:
- Write 4 half-words 0x1234,0x5678,0xABCD,0x0011 -> prog_len=2; mem_valid rises within 2 cycles; mem_in=0x12345678; after pop, mem_in=0xABCD0011; after 2nd pop, mem_valid=0.
- Hold mem_read high 5 cycles on a 3-word program -> exactly one pop; rd_ptr=1.
- After consuming 3 words, pulse mem_zero 1 cycle -> mem_valid=0 during the pulse, then mem_in=word0 again; prog_len stays 3.
- ADDR_W=2: write 5 words (10 half-words) -> full=1 after 4th word; overflow=1; prog_len=4; 5th word never appears.
- Odd half-word 0xBEEF only -> mem_valid stays 0; host_clr -> phase cleared; next pair 0x0001,0x0002 gives mem_in=0x00010002.
- With PROG_CHECKSUM_EN: half-words 0xFFFF,0x0002 -> prog_sum=0x0001; host_clr -> 0x0000; without the macro, prog_sum=0 always.
